// File: rtl/risc_pack.sv
// Shared qrisc32 definitions used by the fetch stage: NOP word, FIFO depth,
// fetch buffer entry and fetch FSM states.
package risc_pack;

  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/qrisc32_fetch_fifo.sv
// Small circular buffer of fetched {instr, pc} words between the instruction
// bus and decode. Flush has priority over push; pop is ignored when empty.
module qrisc32_fetch_fifo
  import risc_pack::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != FULL) | do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qrisc32_fetch.sv
// Instruction fetch stage: Avalon read master feeding a small fetch FIFO,
// with jump/ret redirect that drains any read stuck in wait-request.
module qrisc32_fetch
  import risc_pack::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          DEPTH    = FETCH_DEPTH,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] ibus_address,
  output logic        ibus_rd,
  input  logic [31:0] ibus_data_r,
  input  logic        ibus_wait_req,
  input  logic        jmp_en_i,
  input  logic [31:0] jmp_pc_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);

  fetch_state_t  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   redir_pc, redir_next;
  logic          started;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wdata;
  logic          full, pop, push, accept, stalled;

  qrisc32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (jmp_en_i),
    .wdata   (wdata),
    .head    (head),
    .count   (count)
  );

  // Reads start one cycle after reset release; a full FIFO may still issue when its head is consumed.
  always_comb begin
    full          = (count == CW'(DEPTH));
    instr_valid_o = (count != '0);
    pop           = instr_valid_o & ~stall_i;
    ibus_rd       = started & (~full | pop);
    ibus_address  = pc;
    accept        = ibus_rd & ~ibus_wait_req;
    stalled       = ibus_rd & ibus_wait_req;
    push          = accept & (state == RUN) & ~jmp_en_i;
    wdata.instr   = ibus_data_r;
    wdata.pc      = pc;
    instr_o       = instr_valid_o ? head.instr : NOP;
    pc_o          = instr_valid_o ? head.pc : 32'h0;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    redir_next = redir_pc;
    case (state)
      RUN: begin
        if (jmp_en_i) begin
          if (stalled) begin
            redir_next = jmp_pc_i;
            state_next = DRAIN;
          end else begin
            pc_next = jmp_pc_i;
          end
        end else if (accept) begin
          pc_next = pc + PC_STEP;
        end
      end
      DRAIN: begin
        // The stuck read must complete at its old address before the target is fetched.
        if (jmp_en_i) redir_next = jmp_pc_i;
        if (accept) begin
          pc_next    = jmp_en_i ? jmp_pc_i : redir_pc;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
      started  <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redir_pc <= redir_next;
      started  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qrisc32_fetch.sv
// Directed bench for qrisc32_fetch; memory returns address + 32'h100 with zero latency.
module tb_qrisc32_fetch;
  import risc_pack::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ibus_address;
  logic        ibus_rd;
  logic [31:0] ibus_data_r;
  logic        ibus_wait_req;
  logic        jmp_en_i;
  logic [31:0] jmp_pc_i;
  logic        stall_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;

  int total = 0;
  int bad   = 0;

  qrisc32_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ibus_address  (ibus_address),
    .ibus_rd       (ibus_rd),
    .ibus_data_r   (ibus_data_r),
    .ibus_wait_req (ibus_wait_req),
    .jmp_en_i      (jmp_en_i),
    .jmp_pc_i      (jmp_pc_i),
    .stall_i       (stall_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk = ~clk;

  assign ibus_data_r = ibus_address + 32'h100;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic expectState(input string tag, input logic rd, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic [31:0] instr);
    checkOutput({tag, ".rd"},    {31'h0, ibus_rd},       {31'h0, rd});
    checkOutput({tag, ".addr"},  ibus_address,           addr);
    checkOutput({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, valid});
    checkOutput({tag, ".pc"},    pc_o,                   pc);
    checkOutput({tag, ".instr"}, instr_o,                instr);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic jmp, input logic [31:0] jpc,
                               input logic stall, input logic wr);
    @(negedge clk);
    jmp_en_i      = jmp;
    jmp_pc_i      = jpc;
    stall_i       = stall;
    ibus_wait_req = wr;
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    jmp_en_i      = 1'b0;
    jmp_pc_i      = 32'h0;
    stall_i       = 1'b0;
    ibus_wait_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    expectState("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Sequential fetch after release
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("release.rd", {31'h0, ibus_rd}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t1_first", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      expectState($sformatf("t1_seq%0d", k), 1'b1, 32'(k - 1), 1'b1, 32'(k - 2), 32'(k - 2 + 'h100));
    end

    // Decode stall for five cycles
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    expectState("t2_stall0", 1'b1, 32'd5, 1'b1, 32'd4, 32'h104);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      expectState($sformatf("t2_full%0d", k), 1'b0, 32'd6, 1'b1, 32'd4, 32'h104);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t2_release", 1'b1, 32'd6, 1'b1, 32'd4, 32'h104);
    for (int k = 12; k <= 14; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      expectState($sformatf("t2_seq%0d", k), 1'b1, 32'(k - 5), 1'b1, 32'(k - 7), 32'(k - 7 + 'h100));
    end

    // Redirect with no stalled read
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    expectState("t3_jmp", 1'b1, 32'd10, 1'b1, 32'd8, 32'h108);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t3_t1", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t3_t2", 1'b1, 32'h41, 1'b1, 32'h40, 32'h140);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t3_t3", 1'b1, 32'h42, 1'b1, 32'h41, 32'h141);

    // Redirect during wait-request at address 7
    applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
    expectState("t4_jmp7", 1'b1, 32'h43, 1'b1, 32'h42, 32'h142);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
    expectState("t4_w0", 1'b1, 32'h7, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectState("t4_w1", 1'b1, 32'h7, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectState("t4_w2", 1'b1, 32'h7, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_acc", 1'b1, 32'h7, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_tgt", 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_first", 1'b1, 32'h81, 1'b1, 32'h80, 32'h180);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    expectState("t4_jmpA", 1'b1, 32'h82, 1'b1, 32'h81, 32'h181);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1);
    expectState("t4_jmpB", 1'b1, 32'h82, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_acc2", 1'b1, 32'h82, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_win", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t4_win2", 1'b1, 32'h301, 1'b1, 32'h300, 32'h400);

    // PC wrap, then redirect while popping a full FIFO
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    expectState("t5_jmp", 1'b1, 32'h302, 1'b1, 32'h301, 32'h401);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t5_max", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    expectState("t5_wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFF);
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0);
    expectState("t5_fullpop", 1'b1, 32'h1, 1'b1, 32'hFFFF_FFFF, 32'hFF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t5_empty", 1'b1, 32'h500, 1'b0, 32'h0, 32'h0);

    // Reset while a read is held by wait-request
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectState("t6_wait", 1'b1, 32'h501, 1'b1, 32'h500, 32'h600);
    reset_n = 1'b0;
    #1;
    expectState("t6_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    ibus_wait_req = 1'b0;
    reset_n       = 1'b1;
    #1;
    checkOutput("t6_release.rd", {31'h0, ibus_rd}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t6_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expectState("t6_first", 1'b1, 32'h1, 1'b1, 32'h0, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
